addr_shift_sequencer: RTL and testbench

- Multi-cycle logical shifter placed directly after the address shift-by-one stage.
- Accepts an address, a direction and a shift amount over a valid/ready handshake.
- Applies exactly one 1-bit shift per clock until the requested amount is reached, then holds the result on a valid/ready output until it is consumed.
- Direction encoding matches the shift-by-one stage: 0 = left shift, 1 = right shift, zero fill in both directions.

---
 rtl/addr_shift_sequencer_if.sv | 41 ++++
 rtl/addr_shift_sequencer.sv | 90 +++++++++
 tb/tb_addr_shift_sequencer.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/addr_shift_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : addr_shift_sequencer_if
// Description : Request/result handshake bundle for the multi-cycle
//               address shifter.
// Revision    : 1.0 - initial release
// ============================================================================
interface addr_shift_sequencer_if #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 5
) ();

  // Request side
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_dir;
  logic [AMT_W-1:0] in_amt;

  // Result side
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  // Status
  logic             busy;

  // Requester / consumer view
  modport master (
    output in_valid, in_data, in_dir, in_amt, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  // Shifter view
  modport slave (
    input  in_valid, in_data, in_dir, in_amt, out_ready,
    output in_ready, out_valid, out_data, busy
  );

endinterface
`default_nettype wire

// File: rtl/addr_shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : addr_shift_sequencer
// Description : Multi-cycle logical shifter. Accepts an address, direction
//               and amount, applies one 1-bit zero-fill shift per clock and
//               holds the result on a valid/ready output until consumed.
// Revision    : 1.0 - initial release
// ============================================================================
module addr_shift_sequencer #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  addr_shift_sequencer_if.slave bus
);

  localparam logic [AMT_W-1:0] c_AMT_ZERO = '0;
  localparam logic [AMT_W-1:0] c_AMT_ONE  = {{(AMT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic             dir_q,   dir_d;
  logic [AMT_W-1:0] count_q, count_d;

  // State and datapath registers; reset discards any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      dir_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      dir_q   <= dir_d;
      count_q <= count_d;
    end
  end

  // Next-state and datapath update; request fields are only looked at in IDLE
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    dir_d   = dir_q;
    count_d = count_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          data_d  = bus.in_data;
          dir_d   = bus.in_dir;
          count_d = bus.in_amt;
          // A zero amount skips SHIFT so the input is returned untouched
          state_d = (bus.in_amt == c_AMT_ZERO) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // Amounts beyond WIDTH simply keep shifting zeros through
        data_d  = dir_q ? (data_q >> 1) : (data_q << 1);
        count_d = count_q - c_AMT_ONE;
        if (count_q == c_AMT_ONE) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Handshake outputs decode only the registered state, so there is no
  // combinational path from in_valid or out_ready
  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.out_data  = data_q;

endmodule
`default_nettype wire

// File: tb/tb_addr_shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_addr_shift_sequencer
// Description : Self-checking bench for addr_shift_sequencer. Table-driven
//               requests plus hand-written back-pressure, back-to-back and
//               reset-abort sequences; results checked through a scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_addr_shift_sequencer;

  localparam int WIDTH = 32;
  localparam int AMT_W = 5;

  logic clk;
  logic rst_n;
  int   cyc;

  addr_shift_sequencer_if #(.WIDTH(WIDTH), .AMT_W(AMT_W)) bus ();

  addr_shift_sequencer #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    logic        dir;
    logic [4:0]  amt;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [10];

  // Scoreboard: expected data and latency pushed by the driver, accept edge
  // pushed by the monitor when it sees the handshake
  logic [31:0] exp_q [$];
  int          lat_q [$];
  int          acc_q [$];

  int          n_cmp;
  int          n_fail;
  logic        seen;
  logic [31:0] held;
  int          last_handoff;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Drive a request (starting just after a rising edge) and hold it until taken
  task automatic send(input logic [31:0] d, input logic dr, input logic [4:0] a,
                      input logic [31:0] e, output int acc);
    logic ok;
    exp_q.push_back(e);
    lat_q.push_back(int'(a));
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_dir   = dr;
    bus.in_amt   = a;
    ok  = 1'b0;
    acc = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      fail_now("accept_timeout");
    end else begin
      @(posedge clk);
      #1;
      acc = cyc;
    end
    bus.in_valid = 1'b0;
  endtask

  // Wait for all outstanding results, then confirm the block is back in IDLE
  task automatic wait_idle(input string name);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now({name, "_drain_timeout"});
    @(posedge clk);
    @(negedge clk);
    check({name, "_idle_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    check({name, "_idle_out_valid"}, {31'd0, bus.out_valid}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Output monitor: data and latency on the first valid cycle, stability
  // while held, and retirement on the handoff edge
  initial begin
    seen = 1'b0;
    held = '0;
    last_handoff = -1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        lat_q.delete();
        acc_q.delete();
        seen = 1'b0;
      end else begin
        if (bus.in_valid && bus.in_ready) acc_q.push_back(cyc + 1);
        if (bus.out_valid) begin
          if (!seen) begin
            seen = 1'b1;
            held = bus.out_data;
            if (exp_q.size() == 0 || acc_q.size() == 0) begin
              fail_now("spurious_result");
            end else begin
              check("result_data", bus.out_data, exp_q[0]);
              check("result_latency", 32'(cyc - acc_q[0]), 32'(lat_q[0]));
            end
          end else begin
            check("result_hold", bus.out_data, held);
          end
          if (bus.out_ready) begin
            seen = 1'b0;
            last_handoff = cyc + 1;
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            if (lat_q.size() != 0) void'(lat_q.pop_front());
            if (acc_q.size() != 0) void'(acc_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc1;
    int acc2;

    vecs[0] = '{32'h0000_0001, 1'b0, 5'd4,  32'h0000_0010};
    vecs[1] = '{32'h8000_0003, 1'b1, 5'd1,  32'h4000_0001};
    vecs[2] = '{32'hDEAD_BEEF, 1'b0, 5'd0,  32'hDEAD_BEEF};
    vecs[3] = '{32'hFFFF_FFFF, 1'b0, 5'd31, 32'h8000_0000};
    vecs[4] = '{32'hFFFF_FFFF, 1'b1, 5'd31, 32'h0000_0001};
    vecs[5] = '{32'h1234_5678, 1'b0, 5'd8,  32'h3456_7800};
    vecs[6] = '{32'h1234_5678, 1'b1, 5'd16, 32'h0000_1234};
    vecs[7] = '{32'hA5A5_A5A5, 1'b1, 5'd5,  32'h052D_2D2D};
    vecs[8] = '{32'h0000_0001, 1'b0, 5'd31, 32'h8000_0000};
    vecs[9] = '{32'h8000_0000, 1'b1, 5'd31, 32'h0000_0001};

    n_cmp = 0;
    n_fail = 0;
    cyc = 0;
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_dir    = 1'b0;
    bus.in_amt    = '0;
    bus.out_ready = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_busy",      {31'd0, bus.busy},      32'd0);
    check("rst_out_data",  bus.out_data,           32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Table-driven requests, consumer always ready
    for (int i = 0; i < 10; i++) begin
      send(vecs[i].data, vecs[i].dir, vecs[i].amt, vecs[i].exp, acc1);
      wait_idle("vec");
    end

    // Zero amount under back-pressure
    bus.out_ready = 1'b0;
    send(32'hDEAD_BEEF, 1'b0, 5'd0, 32'hDEAD_BEEF, acc1);
    bus.in_data = 32'h0BAD_F00D;
    bus.in_amt  = 5'd7;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
      check("bp_in_ready",  {31'd0, bus.in_ready},  32'd0);
      check("bp_busy",      {31'd0, bus.busy},      32'd1);
      check("bp_out_data",  bus.out_data,           32'hDEAD_BEEF);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_in_ready",  {31'd0, bus.in_ready},  32'd1);
    check("bp_release_out_valid", {31'd0, bus.out_valid}, 32'd0);
    wait_idle("bp");

    // Back-to-back: second request held while busy, its data driven during SHIFT
    send(32'h0000_0001, 1'b0, 5'd2, 32'h0000_0004, acc1);
    send(32'h0000_0100, 1'b1, 5'd3, 32'h0000_0020, acc2);
    check("b2b_accept_edge", 32'(acc2), 32'(last_handoff + 1));
    wait_idle("b2b");

    // Reset during SHIFT discards the operation
    send(32'h0000_00FF, 1'b0, 5'd10, 32'h0003_FC00, acc1);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    check("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("mid_rst_busy",      {31'd0, bus.busy},      32'd0);
    check("mid_rst_out_data",  bus.out_data,           32'd0);
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("post_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("post_rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    @(posedge clk);
    #1;

    // A fresh request still works after the abort
    send(32'h0000_00FF, 1'b0, 5'd10, 32'h0003_FC00, acc1);
    wait_idle("post_rst");

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
